cpu_bus_arbiter: RTL

CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

---
 rtl/cpu_bus_arbiter_if.sv | 57 +++++
 rtl/cpu_bus_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter_if
// Bundles the requester-side and downstream-side signals of cpu_bus_arbiter.
//   slave  modport : the arbiter itself (consumes requests, drives bus/dn)
//   master modport : the environment (CPU cells and downstream memory)
// Requester side : read_q_a, write_q_a, addr_a, data_a -> read_dn_a,
//                  write_dn_a, data_out
// Downstream side: m_addr, m_data, m_read_q, m_write_q <- m_data_in,
//                  m_read_dn, m_write_dn
// Control/status : rw_halt_in -> bus_busy, grant_idx, timeout_err
// ---------------------------------------------------------------------------
interface cpu_bus_arbiter_if #(
    parameter int CPU_QUANTITY = 4,
    parameter int ADDR_SIZE    = 32,
    parameter int DATA_SIZE    = 32
);
    localparam int GW = (CPU_QUANTITY > 1) ? $clog2(CPU_QUANTITY) : 1;

    logic [CPU_QUANTITY-1:0]           read_q_a;
    logic [CPU_QUANTITY-1:0]           write_q_a;
    logic [CPU_QUANTITY*ADDR_SIZE-1:0] addr_a;
    logic [CPU_QUANTITY*DATA_SIZE-1:0] data_a;
    logic [CPU_QUANTITY-1:0]           read_dn_a;
    logic [CPU_QUANTITY-1:0]           write_dn_a;
    logic [DATA_SIZE-1:0]              data_out;

    logic [ADDR_SIZE-1:0]              m_addr;
    logic [DATA_SIZE-1:0]              m_data;
    logic                              m_read_q;
    logic                              m_write_q;
    logic [DATA_SIZE-1:0]              m_data_in;
    logic                              m_read_dn;
    logic                              m_write_dn;

    logic                              rw_halt_in;
    logic                              bus_busy;
    logic [GW-1:0]                     grant_idx;
    logic                              timeout_err;

    modport slave (
        input  read_q_a, write_q_a, addr_a, data_a,
        output read_dn_a, write_dn_a, data_out,
        output m_addr, m_data, m_read_q, m_write_q,
        input  m_data_in, m_read_dn, m_write_dn,
        input  rw_halt_in,
        output bus_busy, grant_idx, timeout_err
    );

    modport master (
        output read_q_a, write_q_a, addr_a, data_a,
        input  read_dn_a, write_dn_a, data_out,
        input  m_addr, m_data, m_read_q, m_write_q,
        output m_data_in, m_read_dn, m_write_dn,
        output rw_halt_in,
        input  bus_busy, grant_idx, timeout_err
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter
// Round-robin arbiter granting one of CPU_QUANTITY cells access to a single
// downstream read/write port. One transaction at a time: grant, wait for the
// downstream completion, pulse the cell's done, then wait for the cell to
// drop its request before arbitrating again.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - cpu_bus_arbiter_if.slave (requests, downstream port, status)
// Optional feature:
//   CPU_BUS_ARB_TIMEOUT_EN - when defined, a transaction stuck in BUSY for
//   TIMEOUT_CYCLES cycles is abandoned with timeout_err and a done pulse
//   (data_out = 0). When undefined, BUSY waits forever and timeout_err = 0.
// ---------------------------------------------------------------------------
module cpu_bus_arbiter #(
    parameter int CPU_QUANTITY   = 4,
    parameter int ADDR_SIZE      = 32,
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             rst,
    cpu_bus_arbiter_if.slave bus
);
    localparam int GW = (CPU_QUANTITY > 1) ? $clog2(CPU_QUANTITY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           last_grant_q, last_grant_d;
    logic [GW-1:0]           grant_idx_q, grant_idx_d;
    logic [ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [DATA_SIZE-1:0]    data_q, data_d;
    logic                    op_wr_q, op_wr_d;
    logic                    m_rd_q, m_rd_d;
    logic                    m_wr_q, m_wr_d;
    logic [CPU_QUANTITY-1:0] rd_dn_q, rd_dn_d;
    logic [CPU_QUANTITY-1:0] wr_dn_q, wr_dn_d;
    logic [DATA_SIZE-1:0]    dout_q, dout_d;
    logic                    busy_q, busy_d;
    logic                    tmo_err_q, tmo_err_d;

`ifdef CPU_BUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TW-1:0] tmo_inc;
    assign tmo_inc = tmo_cnt_q + TW'(1);
`endif

    logic [CPU_QUANTITY-1:0] req_vec;
    logic                    req_any;
    logic [GW-1:0]           sel_idx;
    logic [GW-1:0]           cand;
    logic                    dn_match;

    assign req_vec  = bus.read_q_a | bus.write_q_a;
    assign dn_match = op_wr_q ? bus.m_write_dn : bus.m_read_dn;

    // Scan starts one past the last completed grant so every cell gets a turn.
    always_comb begin
        req_any = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 0; k < CPU_QUANTITY; k++) begin
            cand = GW'((int'(last_grant_q) + 1 + k) % CPU_QUANTITY);
            if (!req_any && req_vec[cand]) begin
                req_any = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_idx_d  = grant_idx_q;
        addr_d       = addr_q;
        data_d       = data_q;
        op_wr_d      = op_wr_q;
        m_rd_d       = m_rd_q;
        m_wr_d       = m_wr_q;
        rd_dn_d      = '0;
        wr_dn_d      = '0;
        dout_d       = dout_q;
        tmo_err_d    = 1'b0;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.rw_halt_in && req_any) begin
                    grant_idx_d = sel_idx;
                    addr_d      = bus.addr_a[int'(sel_idx)*ADDR_SIZE +: ADDR_SIZE];
                    data_d      = bus.data_a[int'(sel_idx)*DATA_SIZE +: DATA_SIZE];
                    // A cell asking for both gets the write.
                    op_wr_d     = bus.write_q_a[sel_idx];
                    m_rd_d      = !bus.write_q_a[sel_idx];
                    m_wr_d      = bus.write_q_a[sel_idx];
                    state_d     = BUSY;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (dn_match) begin
                    m_rd_d  = 1'b0;
                    m_wr_d  = 1'b0;
                    if (op_wr_q) begin
                        wr_dn_d[grant_idx_q] = 1'b1;
                    end else begin
                        rd_dn_d[grant_idx_q] = 1'b1;
                        dout_d               = bus.m_data_in;
                    end
                    state_d = DONE;
                end
`ifdef CPU_BUS_ARB_TIMEOUT_EN
                else if (tmo_inc == TW'(TIMEOUT_CYCLES)) begin
                    m_rd_d    = 1'b0;
                    m_wr_d    = 1'b0;
                    if (op_wr_q) wr_dn_d[grant_idx_q] = 1'b1;
                    else         rd_dn_d[grant_idx_q] = 1'b1;
                    dout_d    = '0;
                    tmo_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
`endif
            end
            DONE: begin
                // Hold the grant until the cell acknowledges by dropping its request.
                if (!req_vec[grant_idx_q]) begin
                    last_grant_d = grant_idx_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(CPU_QUANTITY - 1);
            grant_idx_q  <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            op_wr_q      <= 1'b0;
            m_rd_q       <= 1'b0;
            m_wr_q       <= 1'b0;
            rd_dn_q      <= '0;
            wr_dn_q      <= '0;
            dout_q       <= '0;
            busy_q       <= 1'b0;
            tmo_err_q    <= 1'b0;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_idx_q  <= grant_idx_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            op_wr_q      <= op_wr_d;
            m_rd_q       <= m_rd_d;
            m_wr_q       <= m_wr_d;
            rd_dn_q      <= rd_dn_d;
            wr_dn_q      <= wr_dn_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            tmo_err_q    <= tmo_err_d;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign bus.read_dn_a  = rd_dn_q;
    assign bus.write_dn_a = wr_dn_q;
    assign bus.data_out   = dout_q;
    assign bus.m_addr     = addr_q;
    assign bus.m_data     = data_q;
    assign bus.m_read_q   = m_rd_q;
    assign bus.m_write_q  = m_wr_q;
    assign bus.bus_busy   = busy_q;
    assign bus.grant_idx  = grant_idx_q;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
    assign bus.timeout_err = tmo_err_q;
`else
    // Never set without the timeout feature; the compare is constant false.
    assign bus.timeout_err = tmo_err_q & (TIMEOUT_CYCLES < 0);
`endif
endmodule
